microsequencer: RTL and testbench

MICROSEQUENCER -- requirements
Module: microsequencer

---
 rtl/microsequencer.sv | 193 +++++++++++++++++++
 tb/tb_microsequencer.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/microsequencer.sv
// Two-phase microsequencer: decodes one program byte per FETCH and drives datapath strobes in EXEC.
// Optional SINGLE_STEP_EN adds a step input so that HALT can run exactly one instruction.
module microsequencer (
  input  logic        clk,
  input  logic        reset,
`ifdef SINGLE_STEP_EN
  input  logic        step,
`endif
  input  logic        run,
  input  logic [7:0]  prog_byte,
  input  logic        alu_cout,
  input  logic        alu_eq,
  output logic        pc_inc,
  output logic        pc_load,
  output logic [11:0] mem_addr,
  output logic [3:0]  opcode,
  output logic [3:0]  operand,
  output logic        acc_we,
  output logic [2:0]  alu_op,
  output logic [1:0]  bus_sel,
  output logic        ram_cs,
  output logic        ram_we,
  output logic        io_in_en,
  output logic        io_out_en,
  output logic        flag_c,
  output logic        flag_z,
  output logic        phase,
  output logic        halted
);

  typedef enum logic [1:0] {StFetch, StExec, StHalt} state_e;

  localparam logic [2:0] AluPassB = 3'd0;
  localparam logic [2:0] AluAdd   = 3'd1;
  localparam logic [2:0] AluSub   = 3'd2;
  localparam logic [2:0] AluNor   = 3'd3;
  localparam logic [2:0] AluPassA = 3'd4;

  localparam logic [1:0] BusRam = 2'd1;
  localparam logic [1:0] BusIn  = 2'd2;
  localparam logic [1:0] BusAlu = 2'd3;

  state_e     state_q, state_d;
  logic [3:0] opcode_q, opcode_d;
  logic [3:0] operand_q, operand_d;
  logic       flag_c_q, flag_c_d;
  logic       flag_z_q, flag_z_d;
  logic       fetch_go;
  logic       flag_upd;
  logic       two_byte;
  logic       taken;

`ifdef SINGLE_STEP_EN
  // Set while a single-stepped instruction is in flight so FETCH ignores run.
  logic step_q, step_d;
  assign fetch_go = run | step_q;
`else
  assign fetch_go = run;
`endif

  assign flag_upd = opcode_q inside {4'h2, 4'h3, 4'hA, 4'hB, 4'hE, 4'hF};
  assign two_byte = opcode_q inside {4'h0, 4'h1, 4'h3, 4'h6, 4'h7, 4'h8, 4'h9, 4'hB, 4'hC,
                                     4'hF};

  always_comb begin
    taken = 1'b0;
    case (opcode_q)
      4'h0:    taken = flag_c_q;
      4'h1:    taken = ~flag_c_q;
      4'h8:    taken = flag_z_q;
      4'h9:    taken = ~flag_z_q;
      4'hC:    taken = 1'b1;
      default: taken = 1'b0;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    opcode_d  = opcode_q;
    operand_d = operand_q;
    flag_c_d  = flag_c_q;
    flag_z_d  = flag_z_q;
`ifdef SINGLE_STEP_EN
    step_d    = step_q;
`endif
    case (state_q)
      StFetch: begin
        if (fetch_go) begin
          opcode_d  = prog_byte[7:4];
          operand_d = prog_byte[3:0];
          state_d   = StExec;
        end else begin
          state_d = StHalt;
        end
      end
      StExec: begin
        if (flag_upd) begin
          flag_c_d = alu_cout;
          flag_z_d = alu_eq;
        end
        state_d = StFetch;
`ifdef SINGLE_STEP_EN
        if (step_q) state_d = StHalt;
        step_d = 1'b0;
`endif
      end
      StHalt: begin
        if (run) state_d = StFetch;
`ifdef SINGLE_STEP_EN
        else if (step) begin
          state_d = StFetch;
          step_d  = 1'b1;
        end
`endif
      end
      default: state_d = StFetch;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= StFetch;
      opcode_q  <= 4'h0;
      operand_q <= 4'h0;
      flag_c_q  <= 1'b0;
      flag_z_q  <= 1'b0;
`ifdef SINGLE_STEP_EN
      step_q    <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      opcode_q  <= opcode_d;
      operand_q <= operand_d;
      flag_c_q  <= flag_c_d;
      flag_z_q  <= flag_z_d;
`ifdef SINGLE_STEP_EN
      step_q    <= step_d;
`endif
    end
  end

  // Outputs are decoded from registered state; reset blanks everything in the same cycle.
  always_comb begin
    pc_inc    = 1'b0;
    pc_load   = 1'b0;
    mem_addr  = 12'h000;
    opcode    = 4'h0;
    operand   = 4'h0;
    acc_we    = 1'b0;
    alu_op    = AluPassB;
    bus_sel   = 2'd0;
    ram_cs    = 1'b0;
    ram_we    = 1'b0;
    io_in_en  = 1'b0;
    io_out_en = 1'b0;
    flag_c    = 1'b0;
    flag_z    = 1'b0;
    phase     = 1'b0;
    halted    = 1'b0;
    if (!reset) begin
      mem_addr = {operand_q, prog_byte};
      opcode   = opcode_q;
      operand  = operand_q;
      flag_c   = flag_c_q;
      flag_z   = flag_z_q;
      case (state_q)
        StFetch: pc_inc = fetch_go;
        StHalt:  halted = 1'b1;
        StExec: begin
          phase   = 1'b1;
          pc_load = taken;
          pc_inc  = two_byte & ~taken;
          case (opcode_q)
            4'h2: alu_op = AluSub;
            4'h3: begin bus_sel = BusRam; ram_cs = 1'b1; alu_op = AluSub; end
            4'h4: acc_we = 1'b1;
            4'h5: begin bus_sel = BusIn; io_in_en = 1'b1; acc_we = 1'b1; end
            4'h6: begin bus_sel = BusRam; ram_cs = 1'b1; acc_we = 1'b1; end
            4'h7: begin bus_sel = BusAlu; alu_op = AluPassA; ram_cs = 1'b1; ram_we = 1'b1; end
            4'hA: begin alu_op = AluAdd; acc_we = 1'b1; end
            4'hB: begin bus_sel = BusRam; ram_cs = 1'b1; alu_op = AluAdd; acc_we = 1'b1; end
            4'hD: begin bus_sel = BusAlu; alu_op = AluPassA; io_out_en = 1'b1; end
            4'hE: begin alu_op = AluNor; acc_we = 1'b1; end
            4'hF: begin bus_sel = BusRam; ram_cs = 1'b1; alu_op = AluNor; acc_we = 1'b1; end
            default: ;
          endcase
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_microsequencer.sv
// Self-checking bench for microsequencer: table-driven reference model checked every cycle,
// plus directed literal expectations.
module tb_microsequencer;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        run = 1'b0;
  logic [7:0]  prog_byte = 8'h00;
  logic        alu_cout = 1'b0;
  logic        alu_eq = 1'b0;
`ifdef SINGLE_STEP_EN
  logic        step_in = 1'b0;
`endif
  logic        pc_inc, pc_load, acc_we, ram_cs, ram_we, io_in_en, io_out_en;
  logic        flag_c, flag_z, phase, halted;
  logic [11:0] mem_addr;
  logic [3:0]  opcode, operand;
  logic [2:0]  alu_op;
  logic [1:0]  bus_sel;

  microsequencer dut (
    .clk       (clk),
    .reset     (reset),
`ifdef SINGLE_STEP_EN
    .step      (step_in),
`endif
    .run       (run),
    .prog_byte (prog_byte),
    .alu_cout  (alu_cout),
    .alu_eq    (alu_eq),
    .pc_inc    (pc_inc),
    .pc_load   (pc_load),
    .mem_addr  (mem_addr),
    .opcode    (opcode),
    .operand   (operand),
    .acc_we    (acc_we),
    .alu_op    (alu_op),
    .bus_sel   (bus_sel),
    .ram_cs    (ram_cs),
    .ram_we    (ram_we),
    .io_in_en  (io_in_en),
    .io_out_en (io_out_en),
    .flag_c    (flag_c),
    .flag_z    (flag_z),
    .phase     (phase),
    .halted    (halted)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  // Per-opcode property tables, bit/index i describes opcode i.
  logic [15:0] two_mask  = 16'h9BCB;
  logic [15:0] acc_mask  = 16'hCC70;
  logic [15:0] flag_mask = 16'hCC0C;
  int bus_tab[16] = '{0, 0, 0, 1, 0, 2, 1, 3, 0, 0, 0, 1, 0, 3, 0, 1};
  int alu_tab[16] = '{0, 0, 2, 2, 0, 0, 0, 4, 0, 0, 1, 1, 0, 4, 3, 3};

  function automatic bit jump_taken(input logic [3:0] op, input bit c, input bit z);
    case (op)
      4'h0: return c;
      4'h1: return !c;
      4'h8: return z;
      4'h9: return !z;
      4'hC: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  localparam int MFetch = 0, MExec = 1, MHalt = 2;
  int         m_where = MFetch;
  logic [3:0] m_op = 4'h0, m_opr = 4'h0;
  bit         m_c = 0, m_z = 0, m_step = 0, m_valid = 0;

  always @(posedge clk) begin
    if (reset) begin
      m_where = MFetch; m_op = 4'h0; m_opr = 4'h0; m_c = 0; m_z = 0; m_step = 0; m_valid = 1;
    end else if (m_valid) begin
      case (m_where)
        MFetch: begin
          if (run || m_step) begin
            m_op = prog_byte[7:4]; m_opr = prog_byte[3:0]; m_where = MExec;
          end else m_where = MHalt;
        end
        MExec: begin
          if (flag_mask[m_op]) begin m_c = alu_cout; m_z = alu_eq; end
          m_where = m_step ? MHalt : MFetch;
          m_step = 0;
        end
        default: begin
          if (run) m_where = MFetch;
`ifdef SINGLE_STEP_EN
          else if (step_in) begin m_where = MFetch; m_step = 1; end
`endif
        end
      endcase
    end
  end

  logic [15:0] e_pci, e_pcl, e_acc, e_alu, e_bus, e_cs, e_we, e_in, e_out;
  bit          ex, tk;

  always @(negedge clk) begin
    if (m_valid) begin
      ex = !reset && m_where == MExec;
      tk = jump_taken(m_op, m_c, m_z);
      e_pci = reset ? 0 : (m_where == MFetch) ? 16'(run | m_step)
                         : ex ? 16'(two_mask[m_op] & !tk) : 0;
      e_pcl = ex ? 16'(tk) : 0;
      e_acc = ex ? 16'(acc_mask[m_op]) : 0;
      e_alu = ex ? 16'(alu_tab[m_op]) : 0;
      e_bus = ex ? 16'(bus_tab[m_op]) : 0;
      e_cs  = ex ? 16'(bus_tab[m_op] == 1 || m_op == 4'h7) : 0;
      e_we  = ex ? 16'(m_op == 4'h7) : 0;
      e_in  = ex ? 16'(m_op == 4'h5) : 0;
      e_out = ex ? 16'(m_op == 4'hD) : 0;
      chk("pc_inc", 16'(pc_inc), e_pci);
      chk("pc_load", 16'(pc_load), e_pcl);
      chk("acc_we", 16'(acc_we), e_acc);
      chk("alu_op", 16'(alu_op), e_alu);
      chk("bus_sel", 16'(bus_sel), e_bus);
      chk("ram_cs", 16'(ram_cs), e_cs);
      chk("ram_we", 16'(ram_we), e_we);
      chk("io_in_en", 16'(io_in_en), e_in);
      chk("io_out_en", 16'(io_out_en), e_out);
      chk("mem_addr", 16'(mem_addr), reset ? 16'h0 : 16'({m_opr, prog_byte}));
      chk("opcode", 16'(opcode), reset ? 16'h0 : 16'(m_op));
      chk("operand", 16'(operand), reset ? 16'h0 : 16'(m_opr));
      chk("flag_c", 16'(flag_c), reset ? 16'h0 : 16'(m_c));
      chk("flag_z", 16'(flag_z), reset ? 16'h0 : 16'(m_z));
      chk("phase", 16'(phase), 16'(ex));
      chk("halted", 16'(halted), 16'(!reset && m_where == MHalt));
    end
  end

  // Drive one cycle of inputs just after the edge, return just after the following negedge.
  task automatic apply(input bit r, input bit rn, input logic [7:0] pb, input bit c, input bit z);
    @(posedge clk);
    #1;
    reset = r; run = rn; prog_byte = pb; alu_cout = c; alu_eq = z;
    @(negedge clk);
    #1;
  endtask

`ifdef SINGLE_STEP_EN
  int n_inc;
`endif

  initial begin
    apply(1, 0, 8'h00, 0, 0);
    apply(1, 1, 8'h47, 1, 1);
    chk("reset_pc_inc", 16'(pc_inc), 16'h0);
    chk("reset_halted", 16'(halted), 16'h0);

    apply(0, 1, 8'h47, 0, 0);
    chk("lit_fetch_pc_inc", 16'(pc_inc), 16'h1);
    chk("lit_fetch_phase", 16'(phase), 16'h0);
    apply(0, 1, 8'h00, 0, 0);
    chk("lit_lit_acc_we", 16'(acc_we), 16'h1);
    chk("lit_lit_bus_sel", 16'(bus_sel), 16'h0);
    chk("lit_lit_alu_op", 16'(alu_op), 16'h0);
    chk("lit_lit_operand", 16'(operand), 16'h7);

    apply(0, 1, 8'h23, 0, 0);
    apply(0, 1, 8'h00, 1, 1);
    chk("cmpi_acc_we", 16'(acc_we), 16'h0);
    apply(0, 1, 8'h81, 0, 0);
    chk("cmpi_flag_c", 16'(flag_c), 16'h1);
    chk("cmpi_flag_z", 16'(flag_z), 16'h1);
    apply(0, 1, 8'h20, 0, 0);
    chk("jz_taken_pc_load", 16'(pc_load), 16'h1);
    chk("jz_taken_pc_inc", 16'(pc_inc), 16'h0);
    chk("jz_taken_mem_addr", 16'(mem_addr), 16'h120);

    apply(0, 1, 8'h23, 0, 0);
    apply(0, 1, 8'h00, 0, 0);
    apply(0, 1, 8'h81, 0, 0);
    apply(0, 1, 8'h20, 0, 0);
    chk("jz_not_taken_pc_inc", 16'(pc_inc), 16'h1);
    chk("jz_not_taken_pc_load", 16'(pc_load), 16'h0);

    apply(0, 1, 8'h7A, 0, 0);
    apply(0, 1, 8'hBC, 0, 0);
    chk("st_ram_cs", 16'(ram_cs), 16'h1);
    chk("st_ram_we", 16'(ram_we), 16'h1);
    chk("st_bus_sel", 16'(bus_sel), 16'h3);
    chk("st_alu_op", 16'(alu_op), 16'h4);
    chk("st_mem_addr", 16'(mem_addr), 16'hABC);

    // Every opcode under varying flag outcomes; the per-cycle model does the checking.
    for (int i = 0; i < 32; i++) begin
      apply(0, 1, {4'(i), 4'(i * 3)}, 0, 0);
      apply(0, 1, 8'(8'h5A + i), i[4], i[0] ^ i[4]);
    end

    apply(0, 1, 8'hA5, 0, 0);
    apply(0, 0, 8'h00, 1, 0);
    chk("addi_drop_acc_we", 16'(acc_we), 16'h1);
    apply(0, 0, 8'h00, 0, 0);
    chk("drop_fetch_pc_inc", 16'(pc_inc), 16'h0);
    apply(0, 0, 8'h00, 0, 0);
    chk("drop_halted", 16'(halted), 16'h1);
    apply(0, 1, 8'h00, 0, 0);
    chk("halt_exit_halted", 16'(halted), 16'h1);
    apply(0, 1, 8'h23, 0, 0);
    chk("resume_pc_inc", 16'(pc_inc), 16'h1);
    apply(0, 1, 8'h00, 1, 1);
    apply(0, 1, 8'hA3, 0, 0);
    chk("pre_reset_flag_c", 16'(flag_c), 16'h1);
    apply(1, 1, 8'h00, 1, 1);
    chk("reset_exec_acc_we", 16'(acc_we), 16'h0);
    chk("reset_exec_phase", 16'(phase), 16'h0);
    apply(0, 1, 8'h00, 0, 0);
    chk("post_reset_phase", 16'(phase), 16'h0);
    chk("post_reset_flag_c", 16'(flag_c), 16'h0);
    chk("post_reset_flag_z", 16'(flag_z), 16'h0);
    apply(0, 1, 8'h00, 0, 0);

`ifdef SINGLE_STEP_EN
    apply(0, 0, 8'h00, 0, 0);
    apply(0, 0, 8'h00, 0, 0);
    step_in = 1'b1;
    chk("step_pre_halted", 16'(halted), 16'h1);
    n_inc = 0;
    for (int i = 0; i < 5; i++) begin
      apply(0, 0, 8'h41, 0, 0);
      step_in = 1'b0;
      if (pc_inc) n_inc++;
    end
    chk("step_pc_inc_count", 16'(n_inc), 16'h1);
    chk("step_post_halted", 16'(halted), 16'h1);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
